relu_backward: RTL and testbench
================================

# relu_backward

Backward-pass companion to the FP32 ReLU activation unit. During the forward pass it records one mask bit per activation input (1 = value passed ReLU). During the backward pass it consumes upstream gradients in the same order and emits the gradient unchanged or as +0.0, according to the stored mask. It sits between the activation stage and the gradient path of the lvg-32 datapath, with ready/valid handshakes on all three streams.

## Interface

- DEPTH, 16, number of mask entries; power of two, minimum 2.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- flush  input  1  synchronous clear of the mask buffer and the output register.
- fwd_valid  input  1  forward value present.
- fwd_x  input  32  forward pre-activation value, IEEE-754 single precision.
- fwd_ready  output  1  mask buffer can accept an entry.
- grad_valid  input  1  upstream gradient present.
- grad  input  32  upstream gradient, FP32.
- grad_ready  output  1  unit accepts the gradient this cycle.
- out_valid  output  1  gated gradient valid.
- out  output  32  gated gradient, FP32.
- out_ready  input  1  downstream accepts out.
- count  output  $clog2(DEPTH)+1  number of stored mask entries.

## Operation

- Mask rule: mask = (fwd_x[31] == 0) && (fwd_x[30:0] != 0).
  - +0.0 gives 0.
  - -0.0 gives 0.
  - Negative values give 0.
  - Positive values, +Inf and positive NaNs give 1.
- Mask buffer: FIFO of DEPTH bits.
  - Write pointer and read pointer each wrap modulo DEPTH.
  - count tracks occupancy, 0..DEPTH.
- Push: fwd_valid && fwd_ready. fwd_ready = (count != DEPTH).
- Pop and gradient accept: grad_valid && grad_ready.
  - grad_ready = (count != 0) && (!out_valid || out_ready).
- On accept: out <= mask ? grad : 32'h00000000; out_valid <= 1.
- Gating is bit-exact: a passed gradient is copied verbatim, including its sign, NaN payloads and denormals.
- Output register:
  - out_valid clears when out_valid && out_ready and no new accept happens in the same cycle.
  - When out_ready and a new accept coincide, the register reloads with out_valid staying 1. This gives full throughput.
- out holds its value while out_valid && !out_ready.
- Simultaneous push and pop: both happen and count is unchanged.
- flush has highest priority. On a flush cycle:
  - Pointers and count go to 0, out_valid goes to 0, out goes to 0.
  - Any push or pop presented in that cycle is discarded.
- Reset has the same effect as flush, applied asynchronously.

## Timing

- Reset values:
  - fwd_ready = 1, grad_ready = 0, out_valid = 0.
  - out = 32'h0, count = 0, pointers = 0.
- Mask written at edge N becomes visible at edge N+1. There is no bypass: with count == 0, grad_ready stays 0 even when a push is in progress that cycle.
- Gradient latency is 1 cycle: accepted at edge N, out_valid high after edge N.
- Throughput is one gradient per cycle while out_ready = 1 and count > 0.
- When full, fwd_ready = 0 even if a pop happens in the same cycle. fwd_ready depends only on registered count.
- fwd_ready and grad_ready are functions of registered state only (count, out_valid) plus the out_ready input. There is no combinational path from fwd_valid or grad_valid.
- Wrap-around: after DEPTH pushes and DEPTH pops, pointers return to 0 and mask order is preserved (FIFO).
- Reset asserted mid-stream clears all state immediately. The first valid push after rst_n rises is at the next rising edge.

## Test plan

- Mask and gate basics:
  - Push 32'hbf800000, 32'h3f800000, 32'h00000000, 32'h80000000.
  - Then send grad 32'h40000000 four times with out_ready = 1.
  - Required out: 0, 40000000, 0, 0, one per cycle, 1-cycle latency.
- Full and empty boundaries:
  - Push DEPTH positive values. count reaches DEPTH and fwd_ready drops.
  - A further push is ignored (count stays DEPTH).
  - Pop all entries; count returns to 0, grad_ready drops, fwd_ready = 1.
- Simultaneous push/pop with count = 3:
  - Assert fwd_valid and grad_valid for 5 cycles; count stays 3 throughout.
  - Outputs follow the FIFO order of the masks.
- Backpressure:
  - Hold out_ready = 0 after one accept. out_valid stays 1, out stays stable, grad_ready = 0, count frozen.
  - Release out_ready; the next grad is accepted in the same cycle.
- Wrap-around: run 3*DEPTH push/pop pairs with an alternating-sign pattern. The gating must match a reference queue exactly.
- Flush and reset mid-stream:
  - With count = 5 and out_valid = 1, pulse flush for one cycle. Then count = 0, out_valid = 0, out = 0.
  - Repeat with rst_n asserted low between edges. The outputs must clear before the next edge.

Source files
------------

// File: rtl/relu_backward.sv
// ReLU backward gate: stores forward-pass masks in a bit FIFO and
// zeroes upstream gradients whose activation did not pass.
module relu_backward #(
  parameter int DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       fwd_valid,
  input  logic [31:0]                fwd_x,
  output logic                       fwd_ready,
  input  logic                       grad_valid,
  input  logic [31:0]                grad,
  output logic                       grad_ready,
  output logic                       out_valid,
  output logic [31:0]                out,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             push;
  logic             pop;
  logic             mask;

  // positive, nonzero encodings (incl. +Inf and positive NaN) pass
  assign mask = !fwd_x[31] && (|fwd_x[30:0]);

  assign fwd_ready  = (count != FULL);
  assign grad_ready = (count != '0) && (!out_valid || out_ready);
  assign push       = fwd_valid && fwd_ready;
  assign pop        = grad_valid && grad_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem       <= '0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out       <= '0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      out       <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= mask;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr    <= rd_ptr + AW'(1);
        out       <= mem[rd_ptr] ? grad : 32'h0;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_relu_backward.sv
// Randomized self-checking bench for relu_backward against a queue model.
module tb_relu_backward;

  localparam int DEPTH = 16;
  localparam int CW = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          fwd_valid;
  logic [31:0]   fwd_x;
  logic          fwd_ready;
  logic          grad_valid;
  logic [31:0]   grad;
  logic          grad_ready;
  logic          out_valid;
  logic [31:0]   out;
  logic          out_ready;
  logic [CW-1:0] count;

  relu_backward #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .fwd_valid(fwd_valid), .fwd_x(fwd_x), .fwd_ready(fwd_ready),
    .grad_valid(grad_valid), .grad(grad), .grad_ready(grad_ready),
    .out_valid(out_valid), .out(out), .out_ready(out_ready),
    .count(count)
  );

  always #5 clk = ~clk;

  int passed = 0;
  int total = 0;

  // reference: queue of pass/block decisions plus the output register
  bit          mq[$];
  logic [31:0] m_out;
  bit          m_ov;

  // a value passes when, read as a signed integer, it is strictly positive
  function automatic bit passes(input logic [31:0] x);
    return $signed(x) > 0;
  endfunction

  function automatic logic [CW-1:0] ecount();
    return CW'(mq.size());
  endfunction

  function automatic logic [31:0] rpos();
    return ($urandom() & 32'h7fffffff) | 32'h1;
  endfunction

  task automatic model_clear();
    mq.delete();
    m_ov = 0;
    m_out = '0;
  endtask

  // one clock: model decides transfers from pre-edge state and inputs
  task automatic tick();
    bit fr, gr, pu, po, m;
    fr = mq.size() < DEPTH;
    gr = (mq.size() > 0) && (!m_ov || out_ready);
    pu = fwd_valid && fr;
    po = grad_valid && gr;
    @(posedge clk);
    #1;
    if (flush) begin
      model_clear();
    end else begin
      if (po) begin
        m = mq.pop_front();
        m_out = m ? grad : 32'h0;
        m_ov = 1;
      end else if (out_ready) begin
        m_ov = 0;
      end
      if (pu) mq.push_back(passes(fwd_x));
    end
  endtask

  task automatic drain();
    int n;
    fwd_valid = 0;
    grad_valid = 1;
    out_ready = 1;
    n = 0;
    while (mq.size() > 0 && n < 4 * DEPTH) begin
      grad = $urandom();
      tick();
      n++;
    end
    grad_valid = 0;
    tick();
    total++;
    if (count !== '0 || out_valid !== 1'b0)
      $display("FAIL drain count=%0d ov=%b want 0/0", count, out_valid);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 0; flush = 0; fwd_valid = 0; grad_valid = 0;
    fwd_x = '0; grad = '0; out_ready = 1;
    model_clear();
    #12;
    total++;
    if (fwd_ready !== 1'b1)
      $display("FAIL rst_fwd_ready got %b want 1", fwd_ready);
    else passed++;
    total++;
    if (grad_ready !== 1'b0)
      $display("FAIL rst_grad_ready got %b want 0", grad_ready);
    else passed++;
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL rst_out_valid got %b want 0", out_valid);
    else passed++;
    total++;
    if (out !== 32'h0)
      $display("FAIL rst_out got %h want 0", out);
    else passed++;
    total++;
    if (count !== '0)
      $display("FAIL rst_count got %0d want 0", count);
    else passed++;
    @(negedge clk);
    rst_n = 1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_mask_gate();
    logic [31:0] vals [4];
    logic [31:0] want [4];
    vals = '{32'hbf800000, 32'h3f800000, 32'h00000000, 32'h80000000};
    want = '{32'h0, 32'h40000000, 32'h0, 32'h0};
    grad = 32'h40000000;
    fwd_valid = 1;
    for (int i = 0; i < 4; i++) begin
      fwd_x = vals[i];
      grad_valid = (i == 0);
      if (i == 0) begin
        total++;
        if (grad_ready !== 1'b0)
          $display("FAIL no_bypass grad_ready=%b want 0", grad_ready);
        else passed++;
      end
      tick();
    end
    fwd_valid = 0;
    total++;
    if (count !== CW'(4))
      $display("FAIL mg_count got %0d want 4", count);
    else passed++;
    grad_valid = 1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (out_valid !== 1'b1 || out !== want[i])
        $display("FAIL mg_out%0d got %b/%h want 1/%h",
                 i, out_valid, out, want[i]);
      else passed++;
    end
    grad_valid = 0;
    tick();
    total++;
    if (out_valid !== 1'b0)
      $display("FAIL mg_idle out_valid=%b want 0", out_valid);
    else passed++;
  endtask

  task automatic test_full_empty();
    fwd_valid = 1;
    for (int i = 0; i < DEPTH; i++) begin
      fwd_x = rpos();
      tick();
    end
    total++;
    if (count !== CW'(DEPTH) || fwd_ready !== 1'b0)
      $display("FAIL full count=%0d fr=%b want %0d/0",
               count, fwd_ready, DEPTH);
    else passed++;
    fwd_x = rpos();
    tick();
    total++;
    if (count !== CW'(DEPTH))
      $display("FAIL full_extra count=%0d want %0d", count, DEPTH);
    else passed++;
    grad_valid = 1;
    grad = $urandom();
    tick();
    total++;
    if (count !== CW'(DEPTH - 1))
      $display("FAIL full_pop_push count=%0d want %0d", count, DEPTH - 1);
    else passed++;
    fwd_valid = 0;
    for (int i = 1; i < DEPTH; i++) begin
      grad = $urandom();
      tick();
      total++;
      if (out_valid !== m_ov || out !== m_out)
        $display("FAIL fe_out%0d got %b/%h want %b/%h",
                 i, out_valid, out, m_ov, m_out);
      else passed++;
    end
    grad_valid = 0;
    total++;
    if (count !== '0 || grad_ready !== 1'b0 || fwd_ready !== 1'b1)
      $display("FAIL empty count=%0d gr=%b fr=%b want 0/0/1",
               count, grad_ready, fwd_ready);
    else passed++;
    tick();
  endtask

  task automatic test_simul();
    fwd_valid = 1;
    for (int i = 0; i < 3; i++) begin
      fwd_x = $urandom();
      tick();
    end
    grad_valid = 1;
    for (int i = 0; i < 5; i++) begin
      fwd_x = $urandom();
      grad = $urandom();
      tick();
      total++;
      if (count !== CW'(3) || out_valid !== m_ov || out !== m_out)
        $display("FAIL simul%0d cnt=%0d out=%b/%h want 3/%b/%h",
                 i, count, out_valid, out, m_ov, m_out);
      else passed++;
    end
    drain();
  endtask

  task automatic test_backpressure();
    logic [31:0] held;
    fwd_valid = 1;
    for (int i = 0; i < 3; i++) begin
      fwd_x = (i == 0) ? rpos() : $urandom();
      tick();
    end
    fwd_valid = 0;
    out_ready = 0;
    grad_valid = 1;
    grad = $urandom();
    tick();
    held = m_out;
    for (int i = 0; i < 3; i++) begin
      grad = $urandom();
      tick();
      total++;
      if (out_valid !== 1'b1 || out !== held ||
          grad_ready !== 1'b0 || count !== CW'(2))
        $display("FAIL bp%0d ov=%b out=%h gr=%b cnt=%0d want 1/%h/0/2",
                 i, out_valid, out, grad_ready, count, held);
      else passed++;
    end
    out_ready = 1;
    #1;
    total++;
    if (grad_ready !== 1'b1)
      $display("FAIL bp_release grad_ready=%b want 1", grad_ready);
    else passed++;
    tick();
    total++;
    if (out_valid !== 1'b1 || out !== m_out || count !== CW'(1))
      $display("FAIL bp_next ov=%b out=%h cnt=%0d want 1/%h/1",
               out_valid, out, count, m_out);
    else passed++;
    drain();
  endtask

  task automatic test_wrap();
    fwd_valid = 1;
    grad_valid = 1;
    for (int i = 0; i < 3 * DEPTH; i++) begin
      fwd_x = {i[0], rpos()[30:0]};
      grad = $urandom();
      tick();
      total++;
      if (out_valid !== m_ov || out !== m_out || count !== ecount())
        $display("FAIL wrap%0d out=%b/%h cnt=%0d want %b/%h/%0d",
                 i, out_valid, out, count, m_ov, m_out, ecount());
      else passed++;
    end
    drain();
  endtask

  task automatic build5();
    fwd_valid = 1;
    for (int i = 0; i < 6; i++) begin
      fwd_x = $urandom();
      tick();
    end
    fwd_valid = 0;
    grad_valid = 1;
    grad = $urandom();
    tick();
    grad_valid = 0;
    out_ready = 0;
    total++;
    if (count !== CW'(5) || out_valid !== 1'b1)
      $display("FAIL build5 cnt=%0d ov=%b want 5/1", count, out_valid);
    else passed++;
  endtask

  task automatic test_flush_reset();
    build5();
    flush = 1;
    fwd_valid = 1;
    grad_valid = 1;
    out_ready = 1;
    tick();
    flush = 0;
    fwd_valid = 0;
    grad_valid = 0;
    total++;
    if (count !== '0 || out_valid !== 1'b0 || out !== 32'h0)
      $display("FAIL flush cnt=%0d ov=%b out=%h want 0/0/0",
               count, out_valid, out);
    else passed++;
    total++;
    if (grad_ready !== 1'b0 || fwd_ready !== 1'b1)
      $display("FAIL flush_ready gr=%b fr=%b want 0/1",
               grad_ready, fwd_ready);
    else passed++;
    build5();
    #2;
    rst_n = 0;
    #1;
    total++;
    if (count !== '0 || out_valid !== 1'b0 || out !== 32'h0)
      $display("FAIL async_rst cnt=%0d ov=%b out=%h want 0/0/0",
               count, out_valid, out);
    else passed++;
    model_clear();
    #2;
    rst_n = 1;
    out_ready = 1;
    fwd_valid = 1;
    fwd_x = rpos();
    tick();
    fwd_valid = 0;
    total++;
    if (count !== CW'(1))
      $display("FAIL post_rst_push cnt=%0d want 1", count);
    else passed++;
    drain();
  endtask

  initial begin
    test_reset();
    test_mask_gate();
    test_full_empty();
    test_simul();
    test_backpressure();
    test_wrap();
    test_flush_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule
